// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId; combinational req, entry and eret at the clock edge.
// Optional macro CP0_EPC_BYPASS_EN forwards a same-cycle mtc0 to EPC onto epc_out.
module cp0_ctrl #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h2021_0C00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc_out
);
    localparam int IPH = 10 + NUM_HWINT - 1;

    logic [NUM_HWINT-1:0] im;
    logic [NUM_HWINT-1:0] ip;
    logic                 exl;
    logic                 ie;
    logic                 bd;
    logic [4:0]           exc_code;
    logic [31:0]          epc;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = (|(ip & im)) & ie & ~exl;
    assign exc_req = (exc_code_in != 5'd0) & ~exl;
    assign take    = int_req | exc_req;
    // Registers are already cleared during reset, but exc_code_in alone could still raise req.
    assign req     = take & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= hwint;
            if (take) begin
                exl      <= 1'b1;
                bd       <= bd_in;
                epc      <= bd_in ? (vpc - 32'd4) : vpc;
                exc_code <= int_req ? 5'd0 : exc_code_in;
            end else begin
                if (we && cp0_addr == 5'd12) begin
                    im  <= cp0_wdata[IPH:10];
                    exl <= cp0_wdata[1];
                    ie  <= cp0_wdata[0];
                end
                if (we && cp0_addr == 5'd14)
                    epc <= cp0_wdata;
                if (eret)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_val          = 32'd0;
        sr_val[IPH:10]  = im;
        sr_val[1]       = exl;
        sr_val[0]       = ie;
        cause_val           = 32'd0;
        cause_val[31]       = bd;
        cause_val[IPH:10]   = ip;
        cause_val[6:2]      = exc_code;
    end

    always_comb begin
        case (cp0_addr)
            5'd12:   cp0_rdata = sr_val;
            5'd13:   cp0_rdata = cause_val;
            5'd14:   cp0_rdata = epc;
            5'd15:   cp0_rdata = PRID_VAL;
            default: cp0_rdata = 32'd0;
        endcase
    end

`ifdef CP0_EPC_BYPASS_EN
    assign epc_out = reset ? 32'd0 : ((we && cp0_addr == 5'd14) ? cp0_wdata : epc);
`else
    assign epc_out = reset ? 32'd0 : epc;
`endif

endmodule
